// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, types and writeback-select encoding for the writeback path
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IMM = 2'b10,
    WB_PC  = 2'b11
  } wb_sel_e;
endpackage

// File: rtl/rf_array.sv
// rtl/rf_array.sv - architectural register storage, one write port, two bypassed read ports
import wb_pkg::*;

module rf_array #(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int NREGS = wb_pkg::NREGS,
  parameter int AW    = wb_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 is forced to zero on read; the bypass covers a write landing this same cycle
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (raddr1 == '0)                  rdata1 = '0;
    else if (wr_en && waddr == raddr1) rdata1 = wdata;
    if (raddr2 == '0)                  rdata2 = '0;
    else if (wr_en && waddr == raddr2) rdata2 = wdata;
  end

endmodule

// File: rtl/wb_regfile_sb.sv
// rtl/wb_regfile_sb.sv - register file with pending-write scoreboard and RAW/WAW issue stall
import wb_pkg::*;

module wb_regfile_sb #(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int NREGS = wb_pkg::NREGS,
  parameter int AW    = wb_pkg::REG_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rs2,
  input  logic             iss_rs1_used,
  input  logic             iss_rs2_used,
  input  logic [AW-1:0]    iss_rd,
  input  logic             iss_rd_we,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             iss_stall,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  rf_wdata,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec,
  output logic             wb_err
);

  logic [NREGS-1:0] busy, clr_vec, set_vec, hz_vec;
  logic             fire;

  rf_array #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (rf_wdata),
    .raddr1 (iss_rs1),
    .raddr2 (iss_rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // A writeback releasing a register this cycle already resolves the hazard on it
  always_comb begin
    clr_vec = '0;
    if (wb_valid && wb_rd != '0) clr_vec[wb_rd] = 1'b1;
  end

  assign hz_vec = busy & ~clr_vec;

  assign iss_stall = iss_valid &&
                     ((iss_rs1_used && iss_rs1 != '0 && hz_vec[iss_rs1]) ||
                      (iss_rs2_used && iss_rs2 != '0 && hz_vec[iss_rs2]) ||
                      (iss_rd_we    && iss_rd  != '0 && hz_vec[iss_rd]));

  assign fire = iss_valid && !iss_stall && !flush;

  always_comb begin
    set_vec = '0;
    if (fire && iss_rd_we && iss_rd != '0) set_vec[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      // set beats a same-cycle release; flush beats both
      if (flush) busy <= '0;
      else       busy <= ((busy & ~clr_vec) | set_vec) & ~NREGS'(1);
      if (wb_valid && wb_rd != '0 && !busy[wb_rd] && !flush) wb_err <= 1'b1;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// tb/tb_wb_regfile_sb.sv - directed self-checking bench for wb_regfile_sb
module tb_wb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_rs1_used, iss_rs2_used, iss_rd_we;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_rd;
  logic [31:0] rs1_data, rs2_data, rf_wdata;
  logic        iss_stall, wb_valid, flush, wb_err;
  logic [31:0] busy_vec;

  int vectors = 0;
  int miscompares = 0;

  wb_regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_used(iss_rs1_used), .iss_rs2_used(iss_rs2_used),
    .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .iss_stall(iss_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .rf_wdata(rf_wdata),
    .flush(flush), .busy_vec(busy_vec), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rs1_used = 0; iss_rs2_used = 0;
    iss_rd = 0; iss_rd_we = 0; wb_valid = 0; wb_rd = 0; rf_wdata = 0; flush = 0;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    idle();
    iss_valid = 1; iss_rd = rd; iss_rd_we = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #3;
    check("reset_busy", busy_vec, 32'h0);
    check("reset_stall", {31'b0, iss_stall}, 32'h0);
    check("reset_err", {31'b0, wb_err}, 32'h0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 32; i++) begin
      iss_rs1 = 5'(i); iss_rs2 = 5'(i);
      #1;
      check($sformatf("reset_x%0d_rs1", i), rs1_data, 32'h0);
      check($sformatf("reset_x%0d_rs2", i), rs2_data, 32'h0);
    end

    // reserve x5, then write it back with same-cycle read
    @(negedge clk); issue_rd(5);
    @(negedge clk); idle();
    check("t2_busy5", busy_vec, 32'h0000_0020);
    wb_valid = 1; wb_rd = 5; rf_wdata = 32'hDEADBEEF; iss_rs1 = 5;
    #1 check("t2_bypass", rs1_data, 32'hDEADBEEF);
    @(negedge clk); idle(); iss_rs1 = 5;
    #1 check("t2_stored", rs1_data, 32'hDEADBEEF);
    check("t2_busy_clear", busy_vec, 32'h0);
    check("t2_err", {31'b0, wb_err}, 32'h0);

    // RAW on x7, resolved by same-cycle writeback
    @(negedge clk); issue_rd(7);
    @(negedge clk); idle();
    check("t3_busy7", busy_vec, 32'h0000_0080);
    iss_valid = 1; iss_rs2 = 7; iss_rs2_used = 1;
    #1 check("t3_raw_stall", {31'b0, iss_stall}, 32'h1);
    wb_valid = 1; wb_rd = 7; rf_wdata = 32'h1234_5678;
    #1 check("t3_raw_resolved", {31'b0, iss_stall}, 32'h0);
    check("t3_rs2_bypass", rs2_data, 32'h1234_5678);
    @(negedge clk); idle();
    check("t3_busy_clear", busy_vec, 32'h0);

    // WAW on x3; set wins over same-cycle release
    @(negedge clk); issue_rd(3);
    @(negedge clk); issue_rd(3);
    #1 check("t4_waw_stall", {31'b0, iss_stall}, 32'h1);
    wb_valid = 1; wb_rd = 3; rf_wdata = 32'hA5A5_0003;
    #1 check("t4_waw_resolved", {31'b0, iss_stall}, 32'h0);
    @(negedge clk); idle();
    check("t4_busy3_kept", busy_vec, 32'h0000_0008);
    wb_valid = 1; wb_rd = 3; rf_wdata = 32'h0000_0333;
    @(negedge clk); idle();
    check("t4_busy3_released", busy_vec, 32'h0);
    check("t4_err", {31'b0, wb_err}, 32'h0);

    // x0 write dropped; unreserved writeback sets sticky error
    wb_valid = 1; wb_rd = 0; rf_wdata = 32'h1;
    @(negedge clk); idle();
    #1 check("t5_x0_zero", rs1_data, 32'h0);
    check("t5_x0_no_err", {31'b0, wb_err}, 32'h0);
    wb_valid = 1; wb_rd = 9; rf_wdata = 32'h0000_0999;
    @(negedge clk); idle();
    check("t5_err_set", {31'b0, wb_err}, 32'h1);
    iss_rs1 = 9;
    #1 check("t5_data_written", rs1_data, 32'h0000_0999);
    @(negedge clk); idle();
    check("t5_err_sticky", {31'b0, wb_err}, 32'h1);

    // flush with a fire on rd=6 clears everything
    @(negedge clk); issue_rd(2);
    @(negedge clk); issue_rd(4);
    @(negedge clk); idle();
    check("t6_busy_2_4", busy_vec, 32'h0000_0014);
    issue_rd(6); flush = 1;
    @(negedge clk); idle();
    check("t6_flush", busy_vec, 32'h0);

    // asynchronous reset mid-cycle while a write is pending
    issue_rd(8);
    @(negedge clk); idle();
    check("t6_busy8", busy_vec, 32'h0000_0100);
    wb_valid = 1; wb_rd = 5; rf_wdata = 32'hFFFF_FFFF;
    #2 rst_n = 0;
    #1 check("t6_rst_busy", busy_vec, 32'h0);
    check("t6_rst_err", {31'b0, wb_err}, 32'h0);
    @(negedge clk); idle(); iss_rs1 = 5; iss_rs2 = 9;
    #1 check("t6_rst_x5", rs1_data, 32'h0);
    check("t6_rst_x9", rs2_data, 32'h0);
    check("t6_rst_stall", {31'b0, iss_stall}, 32'h0);
    rst_n = 1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
